ether_rx_parser: RTL and testbench
==================================

// Module: ether_rx_parser
// PURPOSE
//  Receive-side Ethernet frame parser; counterpart of the transmitter. Takes the MAC's
//  byte stream (preamble/FCS already stripped), filters on destination MAC and EtherType,
//  writes payload bytes to the RX data FIFO, and posts one 12-bit frame-info word per
//  accepted frame. Latches the frame's src/dst MAC and EtherType for the TX frame-info load.
// PARAMETERS
//  MAX_PAYLOAD     1500  payload bytes accepted per frame; excess is dropped and flagged
//  STATUS_TIMEOUT  15    cycles to wait for a MAC good/bad pulse after RXdataValid falls
// PORTS
//  ethRXclock      in   1   RX clock; the only clock
//  reset_n         in   1   reset, asynchronous, active-low
//  myMacAddr       in   48  station address for the destination filter
//  etherTypeFilter in   16  EtherType to accept
//  promiscuous     in   1   1 = skip the destination filter
//  RXdata          in   8   byte from MAC
//  RXdataValid     in   1   high for every byte of a frame, contiguous
//  RXgoodFrame     in   1   1-cycle pulse: last frame passed FCS
//  RXbadFrame      in   1   1-cycle pulse: last frame failed FCS/length
//  rxFifoIn        out  8   payload byte to RX data FIFO
//  rxWrEn          out  1   RX data FIFO write strobe
//  rxFifoFull      in   1   RX data FIFO full
//  rfFifoIn        out  12  frame info: [11]=error, [10:0]=payload bytes written
//  rfWrEn          out  1   frame-info FIFO write strobe
//  rfFifoFull      in   1   frame-info FIFO full
//  frameInfoLoad   out  1   1-cycle pulse: src/dst/type below valid (good frames only)
//  srcMacAddr      out  48  source MAC of last good frame
//  dstMacAddr      out  48  destination MAC of last good frame
//  etherType       out  16  EtherType of last good frame
//  rxFrameCnt      out  16  accepted-good frame count, wraps
//  rxDropCnt       out  16  filtered/dropped/errored frame count, wraps
// BEHAVIOUR
//  Reset: all outputs 0; state R_IDLE. Reset mid-frame: abandon, no FIFO writes after release;
//   bytes of that frame still on RXdataValid are discarded via R_DROP.
//  All outputs registered; rxWrEn/rxFifoIn one cycle after the byte is sampled.
//  States:
//   R_IDLE: RXdataValid=1 -> if rfFifoFull then R_DROP (rxDropCnt++) else R_DST_ADDR;
//    first byte stored, byte counter=1. Status pulses ignored here.
//   R_DST_ADDR: shift bytes 1-6 MSB-first into dst shadow; after byte 6 -> R_SRC_ADDR.
//   R_SRC_ADDR: bytes 7-12 into src shadow -> R_LEN_TYPE.
//   R_LEN_TYPE: bytes 13-14 into type shadow. On byte 14 evaluate filter:
//    pass = (dst==myMacAddr | dst==48'hFFFF_FFFF_FFFF | promiscuous) & type==etherTypeFilter.
//    pass -> R_DATA, length=0, err=0; fail -> R_DROP, rxDropCnt++.
//   R_DATA: each valid byte: if !rxFifoFull & length<MAX_PAYLOAD -> write, length++;
//    else drop byte, err=1. RXdataValid=0 -> R_STATUS, timer=0.
//   R_STATUS: RXgoodFrame -> rfWrEn with {err,length}; if err=0 also frameInfoLoad and
//    update srcMacAddr/dstMacAddr/etherType, rxFrameCnt++, else rxDropCnt++. RXbadFrame or
//    timer==STATUS_TIMEOUT -> rfWrEn with {1,length}, rxDropCnt++. Then R_IDLE.
//    Good and bad same cycle -> treated as bad.
//   R_DROP: wait RXdataValid=0 -> R_IDLE; no writes.
//  Valid falling before byte 14 (runt): no writes, no info word, rxDropCnt++, -> R_IDLE
//   (pending status pulse ignored in R_IDLE).
//  Info FIFO space is checked only at frame start; this block is its sole writer, so
//   the end-of-frame rfWrEn never meets a full FIFO. Consumer discards payload of words with [11]=1.
//  Zero-payload accepted frame: info word {0,11'd0}. Back-to-back frames need >=1 idle
//   cycle plus the status pulse; a frame starting in R_STATUS is handled per R_IDLE once status resolves (its bytes before that go to R_DROP).
//  srcMacAddr/dstMacAddr/etherType hold until the next good frame.
// TESTING
//  Unicast to myMacAddr, type match, 46-byte payload, RXgoodFrame -> 46 rxWrEn in order,
//   rfFifoIn=12'h02E, frameInfoLoad with captured addresses, rxFrameCnt=1.
//  Broadcast dst, wrong type -> no rxWrEn/rfWrEn, rxDropCnt=1; promiscuous=1 with wrong
//   dst, right type -> accepted.
//  rxFifoFull high for 3 payload cycles of 60 -> 57 writes, rfFifoIn=12'h839, no frameInfoLoad.
//  RXbadFrame after 100-byte payload -> rfFifoIn=12'h864, outputs addresses unchanged.
//  10-byte runt; then rfFifoFull at frame start -> no writes either case, rxDropCnt +2.
//  reset_n low mid-payload -> outputs 0 immediately; remaining bytes produce no writes.

Source files
------------

// File: rtl/ether_rx_parser.sv
// rtl/ether_rx_parser.sv - Ethernet RX frame parser: address/type filter, payload and frame-info FIFO writer
module ether_rx_parser #(
    parameter int MAX_PAYLOAD    = 1500,
    parameter int STATUS_TIMEOUT = 15
) (
    input  logic        ethRXclock,
    input  logic        reset_n,
    input  logic [47:0] myMacAddr,
    input  logic [15:0] etherTypeFilter,
    input  logic        promiscuous,
    input  logic [7:0]  RXdata,
    input  logic        RXdataValid,
    input  logic        RXgoodFrame,
    input  logic        RXbadFrame,
    output logic [7:0]  rxFifoIn,
    output logic        rxWrEn,
    input  logic        rxFifoFull,
    output logic [11:0] rfFifoIn,
    output logic        rfWrEn,
    input  logic        rfFifoFull,
    output logic        frameInfoLoad,
    output logic [47:0] srcMacAddr,
    output logic [47:0] dstMacAddr,
    output logic [15:0] etherType,
    output logic [15:0] rxFrameCnt,
    output logic [15:0] rxDropCnt
);
    typedef enum logic [2:0] {
        R_IDLE, R_DST_ADDR, R_SRC_ADDR, R_LEN_TYPE, R_DATA, R_STATUS, R_DROP
    } state_t;

    localparam int TW = $clog2(STATUS_TIMEOUT + 1);

    state_t        state_q;
    logic [111:0]  hdr_q;
    logic [111:0]  hdr_d;
    logic [3:0]    byte_cnt_q;
    logic [10:0]   length_q;
    logic          err_q;
    logic [TW-1:0] timer_q;
    logic          valid_prev_q;
    logic [7:0]    rx_fifo_in_q;
    logic          rx_wr_en_q;
    logic [11:0]   rf_fifo_in_q;
    logic          rf_wr_en_q;
    logic          frame_info_load_q;
    logic [47:0]   src_mac_q;
    logic [47:0]   dst_mac_q;
    logic [15:0]   ether_type_q;
    logic [15:0]   frame_cnt_q;
    logic [15:0]   drop_cnt_q;
    logic          filter_pass;

    // Header shadow holds {dst, src, type} once all 14 header bytes are in
    assign hdr_d = {hdr_q[103:0], RXdata};
    assign filter_pass = ((hdr_d[111:64] == myMacAddr) || (hdr_d[111:64] == 48'hFFFF_FFFF_FFFF)
                          || promiscuous) && (hdr_d[15:0] == etherTypeFilter);

    always_ff @(posedge ethRXclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= R_IDLE;
            hdr_q             <= '0;
            byte_cnt_q        <= '0;
            length_q          <= '0;
            err_q             <= 1'b0;
            timer_q           <= '0;
            // Treat valid as already high so a frame cut by reset is not mistaken for a new start
            valid_prev_q      <= 1'b1;
            rx_fifo_in_q      <= '0;
            rx_wr_en_q        <= 1'b0;
            rf_fifo_in_q      <= '0;
            rf_wr_en_q        <= 1'b0;
            frame_info_load_q <= 1'b0;
            src_mac_q         <= '0;
            dst_mac_q         <= '0;
            ether_type_q      <= '0;
            frame_cnt_q       <= '0;
            drop_cnt_q        <= '0;
        end else begin
            valid_prev_q      <= RXdataValid;
            rx_wr_en_q        <= 1'b0;
            rf_wr_en_q        <= 1'b0;
            frame_info_load_q <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (RXdataValid) begin
                        if (valid_prev_q) begin
                            state_q <= R_DROP;
                        end else if (rfFifoFull) begin
                            state_q    <= R_DROP;
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end else begin
                            hdr_q      <= hdr_d;
                            byte_cnt_q <= 4'd1;
                            state_q    <= R_DST_ADDR;
                        end
                    end
                end
                R_DST_ADDR, R_SRC_ADDR, R_LEN_TYPE: begin
                    if (!RXdataValid) begin
                        state_q    <= R_IDLE;
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end else begin
                        hdr_q      <= hdr_d;
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                        if (byte_cnt_q == 4'd5) begin
                            state_q <= R_SRC_ADDR;
                        end else if (byte_cnt_q == 4'd11) begin
                            state_q <= R_LEN_TYPE;
                        end else if (byte_cnt_q == 4'd13) begin
                            if (filter_pass) begin
                                state_q  <= R_DATA;
                                length_q <= '0;
                                err_q    <= 1'b0;
                            end else begin
                                state_q    <= R_DROP;
                                drop_cnt_q <= drop_cnt_q + 16'd1;
                            end
                        end
                    end
                end
                R_DATA: begin
                    if (RXdataValid) begin
                        if (!rxFifoFull && (length_q < 11'(MAX_PAYLOAD))) begin
                            rx_wr_en_q   <= 1'b1;
                            rx_fifo_in_q <= RXdata;
                            length_q     <= length_q + 11'd1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        state_q <= R_STATUS;
                        timer_q <= '0;
                    end
                end
                R_STATUS: begin
                    if (RXbadFrame || (timer_q == TW'(STATUS_TIMEOUT))) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_fifo_in_q <= {1'b1, length_q};
                        drop_cnt_q   <= drop_cnt_q + 16'd1;
                        state_q      <= R_IDLE;
                    end else if (RXgoodFrame) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_fifo_in_q <= {err_q, length_q};
                        state_q      <= R_IDLE;
                        if (!err_q) begin
                            frame_info_load_q <= 1'b1;
                            dst_mac_q         <= hdr_q[111:64];
                            src_mac_q         <= hdr_q[63:16];
                            ether_type_q      <= hdr_q[15:0];
                            frame_cnt_q       <= frame_cnt_q + 16'd1;
                        end else begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                R_DROP: begin
                    if (!RXdataValid) state_q <= R_IDLE;
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign rxFifoIn      = rx_fifo_in_q;
    assign rxWrEn        = rx_wr_en_q;
    assign rfFifoIn      = rf_fifo_in_q;
    assign rfWrEn        = rf_wr_en_q;
    assign frameInfoLoad = frame_info_load_q;
    assign srcMacAddr    = src_mac_q;
    assign dstMacAddr    = dst_mac_q;
    assign etherType     = ether_type_q;
    assign rxFrameCnt    = frame_cnt_q;
    assign rxDropCnt     = drop_cnt_q;
endmodule

// File: tb/tb_ether_rx_parser.sv
// tb/tb_ether_rx_parser.sv - directed self-checking bench for ether_rx_parser
module tb_ether_rx_parser;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [47:0] myMacAddr;
    logic [15:0] etherTypeFilter;
    logic        promiscuous;
    logic [7:0]  RXdata;
    logic        RXdataValid;
    logic        RXgoodFrame;
    logic        RXbadFrame;
    logic [7:0]  rxFifoIn;
    logic        rxWrEn;
    logic        rxFifoFull;
    logic [11:0] rfFifoIn;
    logic        rfWrEn;
    logic        rfFifoFull;
    logic        frameInfoLoad;
    logic [47:0] srcMacAddr;
    logic [47:0] dstMacAddr;
    logic [15:0] etherType;
    logic [15:0] rxFrameCnt;
    logic [15:0] rxDropCnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  wr_q[$];
    logic [11:0] rf_q[$];
    int          fil_cnt = 0;

    localparam logic [47:0] MY_MAC  = 48'h0200_1122_3344;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_A   = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] SRC_B   = 48'h5A5A_1234_0001;
    localparam logic [47:0] OTHER   = 48'h1234_5678_9ABC;
    localparam logic [15:0] TYPE_OK = 16'h88B5;

    ether_rx_parser dut (
        .ethRXclock(clk), .reset_n(reset_n), .myMacAddr(myMacAddr),
        .etherTypeFilter(etherTypeFilter), .promiscuous(promiscuous),
        .RXdata(RXdata), .RXdataValid(RXdataValid), .RXgoodFrame(RXgoodFrame),
        .RXbadFrame(RXbadFrame), .rxFifoIn(rxFifoIn), .rxWrEn(rxWrEn),
        .rxFifoFull(rxFifoFull), .rfFifoIn(rfFifoIn), .rfWrEn(rfWrEn),
        .rfFifoFull(rfFifoFull), .frameInfoLoad(frameInfoLoad),
        .srcMacAddr(srcMacAddr), .dstMacAddr(dstMacAddr), .etherType(etherType),
        .rxFrameCnt(rxFrameCnt), .rxDropCnt(rxDropCnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxWrEn) wr_q.push_back(rxFifoIn);
        if (rfWrEn) rf_q.push_back(rfFifoIn);
        if (frameInfoLoad) fil_cnt++;
    end

    function automatic logic [7:0] pay(input int i);
        pay = 8'((i * 7 + 3) & 255);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_byte(input logic [7:0] b, input logic full);
        @(negedge clk);
        RXdata      = b;
        RXdataValid = 1'b1;
        rxFifoFull  = full;
    endtask

    task automatic end_bytes();
        @(negedge clk);
        RXdataValid = 1'b0;
        rxFifoFull  = 1'b0;
        RXdata      = 8'h00;
    endtask

    task automatic send_hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ);
        logic [111:0] h;
        h = {dst, src, typ};
        for (int k = 0; k < 14; k++) put_byte(h[111 - 8 * k -: 8], 1'b0);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                              input int n, input int full_lo, input int full_hi);
        send_hdr(dst, src, typ);
        for (int i = 0; i < n; i++) put_byte(pay(i), (i >= full_lo) && (i < full_hi));
        end_bytes();
    endtask

    task automatic status(input logic good, input logic bad);
        cycles(2);
        RXgoodFrame = good;
        RXbadFrame  = bad;
        @(negedge clk);
        RXgoodFrame = 1'b0;
        RXbadFrame  = 1'b0;
        cycles(3);
    endtask

    int wb, rb, fb;

    initial begin
        reset_n = 1'b0; myMacAddr = MY_MAC; etherTypeFilter = TYPE_OK; promiscuous = 1'b0;
        RXdata = 8'h00; RXdataValid = 1'b0; RXgoodFrame = 1'b0; RXbadFrame = 1'b0;
        rxFifoFull = 1'b0; rfFifoFull = 1'b0;
        cycles(3);
        chk("reset_rxWrEn", 64'(rxWrEn), 64'd0);
        chk("reset_rfWrEn", 64'(rfWrEn), 64'd0);
        chk("reset_src", 64'(srcMacAddr), 64'd0);
        chk("reset_cnts", 64'({rxFrameCnt, rxDropCnt}), 64'd0);
        reset_n = 1'b1;
        cycles(2);

        // Unicast, 46-byte payload, good
        wb = wr_q.size(); rb = rf_q.size(); fb = fil_cnt;
        send_frame(MY_MAC, SRC_A, TYPE_OK, 46, -1, -1);
        status(1'b1, 1'b0);
        chk("t1_wr_count", 64'(wr_q.size() - wb), 64'd46);
        for (int i = 0; i < 46 && (wb + i) < wr_q.size(); i++) chk($sformatf("t1_byte%0d", i), 64'(wr_q[wb + i]), 64'(pay(i)));
        chk("t1_rf_count", 64'(rf_q.size() - rb), 64'd1);
        if (rf_q.size() > rb) chk("t1_rf_word", 64'(rf_q[rb]), 64'h02E);
        chk("t1_fil", 64'(fil_cnt - fb), 64'd1);
        chk("t1_src", 64'(srcMacAddr), 64'(SRC_A));
        chk("t1_dst", 64'(dstMacAddr), 64'(MY_MAC));
        chk("t1_type", 64'(etherType), 64'(TYPE_OK));
        chk("t1_frame_cnt", 64'(rxFrameCnt), 64'd1);
        chk("t1_drop_cnt", 64'(rxDropCnt), 64'd0);

        // Broadcast, wrong type: dropped, status pulse ignored
        wb = wr_q.size(); rb = rf_q.size();
        send_frame(BCAST, SRC_B, 16'h0800, 20, -1, -1);
        status(1'b1, 1'b0);
        chk("t2_wr_count", 64'(wr_q.size() - wb), 64'd0);
        chk("t2_rf_count", 64'(rf_q.size() - rb), 64'd0);
        chk("t2_drop_cnt", 64'(rxDropCnt), 64'd1);
        chk("t2_frame_cnt", 64'(rxFrameCnt), 64'd1);

        // Promiscuous, foreign dst, right type: accepted
        promiscuous = 1'b1;
        wb = wr_q.size(); rb = rf_q.size();
        send_frame(OTHER, SRC_B, TYPE_OK, 8, -1, -1);
        status(1'b1, 1'b0);
        promiscuous = 1'b0;
        chk("t3_wr_count", 64'(wr_q.size() - wb), 64'd8);
        if (rf_q.size() > rb) chk("t3_rf_word", 64'(rf_q[rb]), 64'h008);
        else chk("t3_rf_count", 64'(rf_q.size() - rb), 64'd1);
        chk("t3_dst", 64'(dstMacAddr), 64'(OTHER));
        chk("t3_frame_cnt", 64'(rxFrameCnt), 64'd2);

        // RX FIFO full for 3 of 60 payload bytes
        wb = wr_q.size(); rb = rf_q.size(); fb = fil_cnt;
        send_frame(MY_MAC, SRC_A, TYPE_OK, 60, 10, 13);
        status(1'b1, 1'b0);
        chk("t4_wr_count", 64'(wr_q.size() - wb), 64'd57);
        if (rf_q.size() > rb) chk("t4_rf_word", 64'(rf_q[rb]), 64'h839);
        else chk("t4_rf_count", 64'(rf_q.size() - rb), 64'd1);
        chk("t4_fil", 64'(fil_cnt - fb), 64'd0);
        chk("t4_drop_cnt", 64'(rxDropCnt), 64'd2);
        chk("t4_dst_hold", 64'(dstMacAddr), 64'(OTHER));

        // Bad frame after 100-byte payload
        rb = rf_q.size(); fb = fil_cnt;
        send_frame(MY_MAC, SRC_A, TYPE_OK, 100, -1, -1);
        status(1'b0, 1'b1);
        if (rf_q.size() > rb) chk("t5_rf_word", 64'(rf_q[rb]), 64'h864);
        else chk("t5_rf_count", 64'(rf_q.size() - rb), 64'd1);
        chk("t5_fil", 64'(fil_cnt - fb), 64'd0);
        chk("t5_src_hold", 64'(srcMacAddr), 64'(SRC_B));
        chk("t5_dst_hold", 64'(dstMacAddr), 64'(OTHER));
        chk("t5_drop_cnt", 64'(rxDropCnt), 64'd3);

        // 10-byte runt, then frame start with info FIFO full
        wb = wr_q.size(); rb = rf_q.size();
        for (int k = 0; k < 10; k++) put_byte(8'(k), 1'b0);
        end_bytes();
        status(1'b1, 1'b0);
        rfFifoFull = 1'b1;
        send_frame(MY_MAC, SRC_A, TYPE_OK, 10, -1, -1);
        rfFifoFull = 1'b0;
        status(1'b1, 1'b0);
        chk("t6_wr_count", 64'(wr_q.size() - wb), 64'd0);
        chk("t6_rf_count", 64'(rf_q.size() - rb), 64'd0);
        chk("t6_drop_cnt", 64'(rxDropCnt), 64'd5);
        chk("t6_frame_cnt", 64'(rxFrameCnt), 64'd2);

        // No status pulse: timeout closes the frame as errored
        rb = rf_q.size();
        send_frame(MY_MAC, SRC_A, TYPE_OK, 5, -1, -1);
        cycles(25);
        if (rf_q.size() > rb) chk("t7_rf_word", 64'(rf_q[rb]), 64'h805);
        else chk("t7_rf_count", 64'(rf_q.size() - rb), 64'd1);
        chk("t7_drop_cnt", 64'(rxDropCnt), 64'd6);

        // Reset mid-payload
        send_hdr(MY_MAC, SRC_A, TYPE_OK);
        for (int i = 0; i < 20; i++) put_byte(pay(i), 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t8_rst_wr", 64'(rxWrEn), 64'd0);
        chk("t8_rst_src", 64'(srcMacAddr), 64'd0);
        chk("t8_rst_cnts", 64'({rxFrameCnt, rxDropCnt}), 64'd0);
        RXdata = pay(20); RXdataValid = 1'b1;
        put_byte(pay(21), 1'b0);
        reset_n = 1'b1;
        wb = wr_q.size(); rb = rf_q.size();
        for (int i = 22; i < 40; i++) put_byte(pay(i), 1'b0);
        end_bytes();
        status(1'b1, 1'b0);
        chk("t8_wr_after", 64'(wr_q.size() - wb), 64'd0);
        chk("t8_rf_after", 64'(rf_q.size() - rb), 64'd0);
        chk("t8_frame_cnt", 64'(rxFrameCnt), 64'd0);

        // Zero-payload accepted frame
        rb = rf_q.size(); fb = fil_cnt;
        send_frame(BCAST, SRC_B, TYPE_OK, 0, -1, -1);
        status(1'b1, 1'b0);
        if (rf_q.size() > rb) chk("t9_rf_word", 64'(rf_q[rb]), 64'h000);
        else chk("t9_rf_count", 64'(rf_q.size() - rb), 64'd1);
        chk("t9_fil", 64'(fil_cnt - fb), 64'd1);
        chk("t9_dst", 64'(dstMacAddr), 64'(BCAST));
        chk("t9_frame_cnt", 64'(rxFrameCnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
